// File: rtl/pri_enc_pkg.sv
// Shared types and constants for the 8->3 pending-request priority encoder.
// Pulled in by both the selector and the top.
package pri_enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  // Population count of the pending vector. The result is 0..8, so it needs 4 bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_REQ; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/pri_enc_8_3_sel.sv
// Stateless priority selector: picks the highest or lowest set bit of pending.
// The direction is chosen by high_first.
module pri_enc_8_3_sel
  import pri_enc_pkg::*;
(
  input  logic [N_REQ-1:0] pending,
  input  logic             high_first,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Each scan lets its last hit win. The upward scan ends on the top set bit.
  // The downward scan ends on the bottom set bit.
  always_comb begin
    idx_hi = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pending[i]) idx_hi = IDX_W'(i);
    idx_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (pending[i]) idx_lo = IDX_W'(i);
  end

  assign idx = high_first ? idx_hi : idx_lo;
  assign any = |pending;

endmodule

// File: rtl/pri_enc_8_3_n.sv
// Active-low request capture into a pending set, served one index per handshake.
// Service order is highest-first or lowest-first, as set by HIGH_FIRST.
module pri_enc_8_3_n
  import pri_enc_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_n,
  input  logic             load,
  input  logic             ready,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] pending, pending_nxt;
  logic [N_REQ-1:0] load_bits, clr_bits;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             take;

  // Selection sees only registered pending. Bits loaded this cycle compete from the next edge on.
  pri_enc_8_3_sel u_sel (
    .pending    (pending),
    .high_first (HIGH_FIRST),
    .idx        (sel_idx),
    .any        (sel_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: if (sel_any) begin
        state_nxt = OUT;
        take      = 1'b1;
      end
      OUT: if (ready) begin
        if (sel_any) take = 1'b1;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == OUT);
  end

  // A bit moving onto y leaves pending. If the same bit is loaded on that edge, it is absorbed into the move.
  assign load_bits   = load ? ~req_n : '0;
  assign clr_bits    = take ? (N_REQ'(1) << sel_idx) : '0;
  assign pending_nxt = (pending | load_bits) & ~clr_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      y       <= '0;
    end else begin
      pending <= pending_nxt;
      if (take) y <= sel_idx;
    end
  end

  assign count = popcount(pending);
  assign empty = (pending == '0) && !valid;

endmodule

// File: tb/tb_pri_enc_8_3_n.sv
// Directed bench: one HIGH_FIRST=1 and one HIGH_FIRST=0 instance share stimulus.
// A per-instance monitor checks every handshake against a queue of expected indices.
module tb_pri_enc_8_3_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_n;
  logic       load;
  logic       ready;

  logic [2:0] y_h, y_l;
  logic       valid_h, valid_l, empty_h, empty_l;
  logic [3:0] count_h, count_l;

  int checks = 0;
  int errors = 0;
  logic [2:0] q_h[$];
  logic [2:0] q_l[$];
  logic [2:0] exp_h, exp_l;

  always #5 clk = ~clk;

  pri_enc_8_3_n #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst(rst), .req_n(req_n), .load(load), .ready(ready),
    .y(y_h), .valid(valid_h), .empty(empty_h), .count(count_h)
  );

  pri_enc_8_3_n #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req_n(req_n), .load(load), .ready(ready),
    .y(y_l), .valid(valid_l), .empty(empty_l), .count(count_l)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && valid_h && ready) begin
      checks++;
      if (q_h.size() == 0) begin
        errors++;
        $display("FAIL mon_h unexpected output y=%0d", y_h);
      end else begin
        exp_h = q_h.pop_front();
        if (y_h !== exp_h) begin
          errors++;
          $display("FAIL mon_h y got %0d expected %0d", y_h, exp_h);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid_l && ready) begin
      checks++;
      if (q_l.size() == 0) begin
        errors++;
        $display("FAIL mon_l unexpected output y=%0d", y_l);
      end else begin
        exp_l = q_l.pop_front();
        if (y_l !== exp_l) begin
          errors++;
          $display("FAIL mon_l y got %0d expected %0d", y_l, exp_l);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; req_n = 8'hFF; ready = 1'b0;
    #12;
    chk("rst_valid_h", valid_h, 0); chk("rst_empty_h", empty_h, 1);
    chk("rst_count_h", count_h, 0); chk("rst_y_h", y_h, 0);
    chk("rst_valid_l", valid_l, 0); chk("rst_empty_l", empty_l, 1);
    chk("rst_count_l", count_l, 0); chk("rst_y_l", y_l, 0);
    rst = 1'b0;

    // Single request on index 0: one-cycle latency, then one handshake
    req_n = 8'b1111_1110; load = 1'b1;
    q_h.push_back(3'd0); q_l.push_back(3'd0);
    tick(); load = 1'b0; req_n = 8'hFF;
    chk("lat_valid0_h", valid_h, 0); chk("lat_empty0_h", empty_h, 0); chk("lat_count_h", count_h, 1);
    tick();
    chk("lat_valid1_h", valid_h, 1); chk("lat_y_h", y_h, 0); chk("lat_empty1_h", empty_h, 0);
    chk("lat_count1_h", count_h, 0); chk("lat_valid1_l", valid_l, 1); chk("lat_y_l", y_l, 0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("lat_done_valid_h", valid_h, 0); chk("lat_done_empty_h", empty_h, 1);
    chk("lat_done_empty_l", empty_l, 1);

    // Bits 2,5,7 streamed back-to-back with ready held high
    ready = 1'b1; req_n = 8'b0101_1011; load = 1'b1;
    q_h.push_back(3'd7); q_h.push_back(3'd5); q_h.push_back(3'd2);
    q_l.push_back(3'd2); q_l.push_back(3'd5); q_l.push_back(3'd7);
    tick(); load = 1'b0; req_n = 8'hFF;
    chk("b2b_count_h", count_h, 3); chk("b2b_valid0_h", valid_h, 0);
    tick(); chk("b2b_first_h", y_h, 7); chk("b2b_first_l", y_l, 2);
    tick(); chk("b2b_second_h", y_h, 5); chk("b2b_second_l", y_l, 5);
    tick(); chk("b2b_third_h", y_h, 2); chk("b2b_third_l", y_l, 7);
    tick();
    chk("b2b_idle_h", valid_h, 0); chk("b2b_empty_h", empty_h, 1);
    chk("b2b_idle_l", valid_l, 0); chk("b2b_empty_l", empty_l, 1);
    ready = 1'b0;

    // Same load, stalled for 5 cycles before draining
    req_n = 8'b0101_1011; load = 1'b1;
    q_h.push_back(3'd7); q_h.push_back(3'd5); q_h.push_back(3'd2);
    q_l.push_back(3'd2); q_l.push_back(3'd5); q_l.push_back(3'd7);
    tick(); load = 1'b0; req_n = 8'hFF;
    tick();
    chk("stall_y_h", y_h, 7); chk("stall_count_h", count_h, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_y_l", y_l, 2); chk("stall_valid_l", valid_l, 1); chk("stall_count_l", count_l, 2);
    end
    ready = 1'b1; repeat (3) tick(); ready = 1'b0;
    chk("stall_idle_h", valid_h, 0); chk("stall_idle_l", valid_l, 0); chk("stall_empty_l", empty_l, 1);

    // Re-requesting the index on y while stalled delivers it twice
    req_n = 8'b1111_0111; load = 1'b1;
    q_h.push_back(3'd3); q_h.push_back(3'd3);
    q_l.push_back(3'd3); q_l.push_back(3'd3);
    tick(); load = 1'b0; req_n = 8'hFF;
    tick(); chk("dup_y_h", y_h, 3); chk("dup_count0_h", count_h, 0);
    req_n = 8'b1111_0111; load = 1'b1;
    tick(); load = 1'b0; req_n = 8'hFF;
    chk("dup_count1_h", count_h, 1); chk("dup_count1_l", count_l, 1); chk("dup_hold_y_l", y_l, 3);
    ready = 1'b1; tick();
    chk("dup_again_h", y_h, 3); chk("dup_again_valid_h", valid_h, 1);
    tick(); ready = 1'b0;
    chk("dup_idle_h", valid_h, 0); chk("dup_empty_l", empty_l, 1);

    // A load on the handshake edge is not eligible for that edge's selection
    req_n = 8'b1110_1101; load = 1'b1;
    q_h.push_back(3'd4); q_h.push_back(3'd1); q_h.push_back(3'd7);
    q_l.push_back(3'd1); q_l.push_back(3'd4); q_l.push_back(3'd7);
    tick(); load = 1'b0; req_n = 8'hFF;
    tick(); chk("sim_y_h", y_h, 4); chk("sim_y_l", y_l, 1);
    ready = 1'b1; req_n = 8'b0111_1111; load = 1'b1;
    tick(); load = 1'b0; req_n = 8'hFF;
    chk("sim_next_h", y_h, 1); chk("sim_next_l", y_l, 4); chk("sim_count_h", count_h, 1);
    repeat (2) tick(); ready = 1'b0;
    chk("sim_idle_h", valid_h, 0); chk("sim_idle_l", valid_l, 0);

    // Asynchronous reset mid-stream discards y and pending
    req_n = 8'b0000_0111; load = 1'b1;
    tick(); load = 1'b0; req_n = 8'hFF;
    tick(); chk("mid_count_h", count_h, 4); chk("mid_count_l", count_l, 4); chk("mid_valid_h", valid_h, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid_h", valid_h, 0); chk("arst_count_h", count_h, 0); chk("arst_empty_h", empty_h, 1);
    chk("arst_valid_l", valid_l, 0); chk("arst_count_l", count_l, 0); chk("arst_y_l", y_l, 0);
    ready = 1'b1;
    tick(); chk("arst_hold_valid_h", valid_h, 0);
    #2 rst = 1'b0;

    // An all-ones load in IDLE does nothing, and no stale output appears
    req_n = 8'hFF; load = 1'b1;
    tick(); load = 1'b0;
    repeat (2) tick();
    chk("ff_valid_h", valid_h, 0); chk("ff_empty_h", empty_h, 1);
    chk("ff_valid_l", valid_l, 0); chk("ff_empty_l", empty_l, 1); chk("ff_count_l", count_l, 0);

    // A load on the first edge after reset release is captured
    rst = 1'b1; #2 rst = 1'b0;
    req_n = 8'b1011_1111; load = 1'b1;
    q_h.push_back(3'd6); q_l.push_back(3'd6);
    tick(); load = 1'b0; req_n = 8'hFF;
    chk("post_rst_count_h", count_h, 1);
    tick(); chk("post_rst_y_h", y_h, 6); chk("post_rst_y_l", y_l, 6);
    tick(); chk("post_rst_idle_h", valid_h, 0);
    ready = 1'b0;

    repeat (2) tick();
    chk("drain_h", q_h.size(), 0);
    chk("drain_l", q_l.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pri_enc_8_3_n.md
PRI_ENC_8_3_N -- requirements
Module: pri_enc_8_3_n

Interface
REQ-001 Parameter HIGH_FIRST, default 1: when 1 the highest set index is served first; when 0 the lowest set index is served first.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_n  input  8  active-low request lines; bit i = 0 means index i is requesting.
REQ-005 load  input  1  when 1, the requests on req_n are captured this cycle.
REQ-006 y  output  3  binary index being offered.
REQ-007 valid  output  1  y holds a valid index.
REQ-008 ready  input  1  consumer accepts y this cycle.
REQ-009 empty  output  1  asserted when pending is zero and valid is 0.
REQ-010 count  output  4  number of set bits in pending, excluding the index held on y (range 0..8).

Function
REQ-011 The block SHALL hold an internal 8-bit pending register; on a clk edge with load=1, pending SHALL become pending | ~req_n, minus any bit removed at that same edge per REQ-014.
REQ-012 The FSM SHALL have two states. IDLE: valid=0. OUT: valid=1.
REQ-013 IDLE->OUT: when pending != 0, the selected index SHALL be registered into y, and its pending bit cleared, at the next edge. Latency from the load edge to valid=1 is 1 clock.
REQ-014 Index selection SHALL use pending as registered, before the current cycle's load: highest set bit if HIGH_FIRST=1, else lowest set bit.
REQ-015 In OUT with valid & ready, the edge SHALL be a handshake.
  - If pending != 0: the next index SHALL load into y at that same edge and the block stays in OUT, giving back-to-back throughput of 1 per clock.
  - If pending == 0: the block SHALL go to IDLE.
REQ-016 In OUT with ready=0, y and valid SHALL hold stable, and pending SHALL continue to accumulate loads.
REQ-017 A load re-asserting the index currently on y SHALL set that bit in pending, so the index is delivered again later. No merging.
REQ-018 A load of a bit already pending SHALL have no effect (OR semantics). A load with req_n = 8'hFF SHALL have no effect.
REQ-019 Simultaneous load and handshake: selection per REQ-014, with newly loaded bits eligible from the following cycle.
REQ-020 count and empty SHALL be combinational functions of the registered state only, with no path from req_n, load or ready.

Reset
REQ-021 Asserting rst SHALL immediately and asynchronously set state=IDLE, pending=8'h00, y=3'd0, valid=0; hence empty=1 and count=0.
REQ-022 Reset mid-operation SHALL discard all pending and held indices without emitting them.
REQ-023 On the first edge after rst deasserts, the block SHALL accept load normally.

Structure
REQ-024 A shared package pri_enc_pkg SHALL hold:
  - the state enum typedef (IDLE, OUT);
  - the constants N_REQ=8 and IDX_W=3.
REQ-025 The combinational selector SHALL be a sub-module pri_enc_8_3_sel with ports: 8-bit pending vector and HIGH_FIRST in; 3-bit index and any-set out.
REQ-026 All sequential logic SHALL reside in pri_enc_8_3_n; the sub-module SHALL contain no state.

Verification
REQ-027 Reset, then load with req_n=8'b1111_1110 -> valid=1 one clock later, y=0; empty=0 only until the handshake.
REQ-028 HIGH_FIRST=1, load req_n=8'b0101_1011, ready held at 1 -> y sequence 7,5,2 on consecutive clocks, then valid=0 and empty=1.
REQ-029 HIGH_FIRST=0, same load with ready=0 for 5 clocks -> y=2 held stable, count=2; then ready=1 -> sequence 2,5,7.
REQ-030 Holding y=3, ready=0: load req_n=8'b1111_0111 -> after handshakes, 3 is delivered twice in total.
REQ-031 rst asserted mid-stream with count=4 -> same cycle valid=0 and count=0, with no further outputs.
REQ-032 Load req_n=8'hFF in IDLE -> valid stays 0, empty stays 1.
